// File: rtl/procyon_fifo_stream_adapter_pkg.sv
// Shared sizing helpers for the FIFO-to-stream adapter and its skid buffer.
package procyon_fifo_stream_adapter_pkg;

    // Index width for a pointer into n entries; never narrower than one bit.
    function automatic int c2i(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/procyon_fifo_stream_adapter_if.sv
// FIFO read-side and valid/ready stream signals of the adapter.
// master: the adapter itself; slave: the FIFO/consumer environment.
interface procyon_fifo_stream_adapter_if #(
    parameter int OPTN_DATA_WIDTH = 8
);
    logic                       i_flush;
    logic                       o_fifo_ack;
    logic                       i_fifo_empty;
    logic [OPTN_DATA_WIDTH-1:0] i_fifo_data;
    logic                       o_valid;
    logic [OPTN_DATA_WIDTH-1:0] o_data;
    logic                       i_ready;

    modport master (
        input  i_flush, i_fifo_empty, i_fifo_data, i_ready,
        output o_fifo_ack, o_valid, o_data
    );

    modport slave (
        output i_flush, i_fifo_empty, i_fifo_data, i_ready,
        input  o_fifo_ack, o_valid, o_data
    );
endinterface

// File: rtl/procyon_skid_buf.sv
// Circular skid buffer: entry storage, head/tail pointers and occupancy.
// Flush empties the buffer in one cycle; reset additionally clears the storage.
module procyon_skid_buf
    import procyon_fifo_stream_adapter_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH = 8,
    parameter int OPTN_BUF_DEPTH  = 2,
    localparam int IW = c2i(OPTN_BUF_DEPTH),
    localparam int OW = occ_w(OPTN_BUF_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [OPTN_DATA_WIDTH-1:0] push_data,
    input  logic                       pop,
    output logic                       valid,
    output logic [OPTN_DATA_WIDTH-1:0] data,
    output logic [OW-1:0]              occ
);

    logic [OPTN_DATA_WIDTH-1:0] mem [OPTN_BUF_DEPTH];
    logic [IW-1:0]              head;
    logic [IW-1:0]              tail;
    logic [OW-1:0]              occ_q;
    logic                       pop_ok;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return (p == IW'(OPTN_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (occ_q != '0);
    assign data   = mem[head];
    assign occ    = occ_q;
    assign pop_ok = pop & valid;

    // Storage, pointers and occupancy; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OPTN_BUF_DEPTH; i++) mem[i] <= '0;
            head  <= '0;
            tail  <= '0;
            occ_q <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            occ_q <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= nxt(tail);
            end
            if (pop_ok) head <= nxt(head);
            case ({push, pop_ok})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: ;
            endcase
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= OW'(OPTN_BUF_DEPTH));

endmodule

// File: rtl/procyon_fifo_stream_adapter.sv
// Converts the FIFO ack/empty read port (one-cycle read latency) into a
// valid/ready stream. Reads are only issued when a buffer slot is reserved
// for the returning word, counting the word already in flight.
// Optional: PCYN_FIFO_STREAM_CNT_EN adds o_xfer_cnt, a 32-bit pop counter.
module procyon_fifo_stream_adapter
    import procyon_fifo_stream_adapter_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH = 8,
    parameter int OPTN_BUF_DEPTH  = 2
) (
    input  logic clk,
    input  logic rst,
    procyon_fifo_stream_adapter_if.master bus
`ifdef PCYN_FIFO_STREAM_CNT_EN
    ,
    output logic [31:0] o_xfer_cnt
`endif
);

    localparam int OW = occ_w(OPTN_BUF_DEPTH);

    logic          inflight;
    logic          pop;
    logic          ack;
    logic [OW-1:0] occ;
    logic [OW:0]   credit;

    assign pop    = bus.o_valid & bus.i_ready;
    // One bit wider than occ so occ+inflight cannot wrap.
    assign credit = {1'b0, occ} + (OW+1)'(inflight) - (OW+1)'(pop);

    // Read request: only when the returning word is guaranteed a slot.
    always_comb begin
        ack = 1'b0;
        if (!rst && !bus.i_flush && !bus.i_fifo_empty)
            ack = (credit < (OW+1)'(OPTN_BUF_DEPTH));
    end

    assign bus.o_fifo_ack = ack;

    // Tracks the read whose data arrives on i_fifo_data this cycle.
    always_ff @(posedge clk) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= ack;
    end

    procyon_skid_buf #(
        .OPTN_DATA_WIDTH (OPTN_DATA_WIDTH),
        .OPTN_BUF_DEPTH  (OPTN_BUF_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.i_flush),
        .push      (inflight & ~bus.i_flush),
        .push_data (bus.i_fifo_data),
        .pop       (pop),
        .valid     (bus.o_valid),
        .data      (bus.o_data),
        .occ       (occ)
    );

`ifdef PCYN_FIFO_STREAM_CNT_EN
    // Pop counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)      o_xfer_cnt <= '0;
        else if (pop) o_xfer_cnt <= o_xfer_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_procyon_fifo_stream_adapter.sv
// Bench for procyon_fifo_stream_adapter: a queue-based FIFO feeds the DUT and
// a queue of expected beats describes what the stream must show each cycle.
module tb_procyon_fifo_stream_adapter;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    procyon_fifo_stream_adapter_if #(.OPTN_DATA_WIDTH(DW)) bus ();

`ifdef PCYN_FIFO_STREAM_CNT_EN
    logic [31:0] o_xfer_cnt;
`endif

    procyon_fifo_stream_adapter #(
        .OPTN_DATA_WIDTH (DW),
        .OPTN_BUF_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PCYN_FIFO_STREAM_CNT_EN
        ,
        .o_xfer_cnt (o_xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic          ret_valid = 1'b0;
    logic [DW-1:0] ret_data  = '0;
    logic          rst_prev  = 1'b0;
    logic          armed     = 1'b0;
    int            acks  = 0;
    int            beats = 0;
    int            cyc   = 0;
    logic          s_valid, s_ack;
    logic [DW-1:0] s_data;
    logic [31:0]   cnt_model = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rdy, input logic fl, input logic rs);
        logic          pop_e;
        logic          exp_ack;
        logic          nret_v;
        logic [DW-1:0] nret_d;
        int            room;
        @(negedge clk);
        rst              = rs;
        bus.i_ready      = rdy;
        bus.i_flush      = fl;
        bus.i_fifo_empty = (fifo_q.size() == 0);
        bus.i_fifo_data  = ret_valid ? ret_data : DW'($urandom());
        #1;
        s_valid = bus.o_valid;
        s_ack   = bus.o_fifo_ack;
        s_data  = bus.o_data;
        pop_e   = (exp_q.size() != 0) && rdy;
        room    = exp_q.size() + int'(ret_valid) - int'(pop_e);
        exp_ack = !rs && !fl && (fifo_q.size() != 0) && (room < DEPTH);
        if (armed) begin
            chk_val("valid", 32'(s_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk_val("data", 32'(s_data), 32'(exp_q[0]));
            if (rst_prev) chk_val("rst_data", 32'(s_data), 32'd0);
            chk_val("ack", 32'(s_ack), 32'(exp_ack));
`ifdef PCYN_FIFO_STREAM_CNT_EN
            chk_val("xfer_cnt", o_xfer_cnt, cnt_model);
`endif
        end
        if (s_ack) acks++;
        if (pop_e) begin
            got_q.push_back(exp_q.pop_front());
            beats++;
        end
        if (rs) cnt_model = 0;
        else if (pop_e) cnt_model = cnt_model + 1;
        if (ret_valid && !fl && !rs) exp_q.push_back(ret_data);
        nret_v = s_ack && (fifo_q.size() != 0) && !fl;
        nret_d = nret_v ? fifo_q.pop_front() : '0;
        if (fl || rs) exp_q.delete();
        if (fl) fifo_q.delete();
        ret_valid = nret_v;
        ret_data  = nret_d;
        rst_prev  = rs;
        if (rs) armed = 1'b1;
        cyc++;
        @(posedge clk);
    endtask

    initial begin
        int first_ack;
        int first_val;
        int last_val;
        int rel_cyc;
        int b0;
        rst              = 1'b1;
        bus.i_flush      = 1'b0;
        bus.i_ready      = 1'b0;
        bus.i_fifo_empty = 1'b1;
        bus.i_fifo_data  = '0;

        // Reset with a non-empty FIFO, then stream 0x01..0x08.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        repeat (3) step(1'b1, 1'b0, 1'b1);
        first_ack = -1; first_val = -1; last_val = -1; rel_cyc = cyc;
        b0 = beats;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (s_ack && first_ack < 0) first_ack = cyc - 1;
            if (s_valid) begin
                if (first_val < 0) first_val = cyc - 1;
                last_val = cyc - 1;
            end
        end
        chk_val("first_ack_cycle", 32'(first_ack), 32'(rel_cyc));
        chk_val("stream_latency", 32'(first_val - first_ack), 32'd2);
        chk_val("stream_span", 32'(last_val - first_val), 32'd7);
        chk_val("stream_beats", 32'(beats - b0), 32'd8);

        // Backpressure: five words queued, consumer stalled.
        for (int i = 1; i <= 5; i++) fifo_q.push_back(DW'(i));
        acks = 0;
        repeat (6) step(1'b0, 1'b0, 1'b0);
        chk_val("bp_acks", 32'(acks), 32'd2);
        chk_val("bp_valid", 32'(s_valid), 32'd1);
        chk_val("bp_head", 32'(s_data), 32'h01);
        b0 = beats;
        got_q.delete();
        repeat (10) step(1'b1, 1'b0, 1'b0);
        chk_val("bp_beats", 32'(beats - b0), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < got_q.size()) chk_val("bp_order", 32'(got_q[i]), 32'(i + 1));

        // Ready toggling over 16 words.
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(8'h40 + i));
        b0 = beats;
        for (int i = 0; i < 40; i++) step(((i % 2) == 0), 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        chk_val("toggle_beats", 32'(beats - b0), 32'd16);

        // Flush with one word buffered and one in flight.
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h30 + i));
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_val("flush_ack", 32'(s_ack), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk_val("flush_valid", 32'(s_valid), 32'd0);
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'hA0 + i));
        got_q.delete();
        repeat (8) step(1'b1, 1'b0, 1'b0);
        chk_val("flush_cnt", 32'(got_q.size()), 32'd4);
        if (got_q.size() != 0) chk_val("flush_first", 32'(got_q[0]), 32'hA0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            logic rdy, fl, rs;
            if (fifo_q.size() < 20 && $urandom_range(0, 1) == 1)
                fifo_q.push_back(DW'($urandom()));
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 49) == 0);
            rs  = ($urandom_range(0, 199) == 0);
            step(rdy, fl, rs);
        end
        repeat (40) step(1'b1, 1'b0, 1'b0);
        chk_val("drain_valid", 32'(s_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
